fir_xifu_issuer: RTL and testbench

FIR_XIFU_ISSUER -- requirements
Module: fir_xifu_issuer

---
 rtl/fir_xifu_issuer.sv | 231 +++++++++++++++++++++++
 tb/tb_fir_xifu_issuer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_issuer.sv
// Offloads xfirlw/xfirsw/xfirdotp to a coprocessor over an XIF-style issue/commit/result interface.
// Define FIR_XIFU_ISSUER_SCOREBOARD_EN to stall commands whose sources match a pending destination register.
module fir_xifu_issuer #(
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [4:0]            cmd_rs1_i,
  input  logic [4:0]            cmd_rs2_i,
  input  logic [4:0]            cmd_rd_i,
  input  logic [11:0]           cmd_imm_i,
  input  logic [31:0]           cmd_opa_i,
  input  logic [31:0]           cmd_opb_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_instr_o,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  output logic [31:0]           issue_rs0_o,
  output logic [31:0]           issue_rs1_o,
  input  logic                  issue_accept_i,
  output logic                  commit_valid_o,
  output logic                  commit_kill_o,
  output logic [X_ID_WIDTH-1:0] commit_id_o,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  input  logic [31:0]           result_data_i,
  input  logic [4:0]            result_rd_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  err_o
);

  localparam logic [6:0] OPCODE  = 7'b1011011;
  localparam logic [1:0] OP_INV  = 2'b00;
  localparam logic [1:0] OP_DOTP = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

  state_e                state_q, state_d;
  logic [31:0]           instr_q, instr_d, opa_q, opa_d, opb_q, opb_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d, id_cnt_q, id_cnt_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [X_ID_WIDTH-1:0] q_id_q [MAX_OUTSTANDING];
  logic [X_ID_WIDTH-1:0] q_id_d [MAX_OUTSTANDING];
  logic [4:0]            q_rd_q [MAX_OUTSTANDING];
  logic [4:0]            q_rd_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] q_vld_q, q_vld_d;
  logic                  err_q, err_d, rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  hazard, cmd_fire, issue_fire, res_fire, push, pop;
  logic [31:0]           enc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef FIR_XIFU_ISSUER_SCOREBOARD_EN
  // A register index of zero never creates a dependency.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (q_vld_q[i]) begin
        if ((cmd_rs1_i != 5'd0) && (cmd_rs1_i == q_rd_q[i])) hazard = 1'b1;
        if (((cmd_op_i == OP_SW) || (cmd_op_i == OP_DOTP)) &&
            (cmd_rs2_i != 5'd0) && (cmd_rs2_i == q_rd_q[i])) hazard = 1'b1;
      end
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign cmd_ready_o    = rst_ni && (state_q == IDLE) && (cnt_q < MAX_CNT) && !hazard;
  assign cmd_fire       = cmd_valid_i && cmd_ready_o;
  assign issue_fire     = (state_q == ISSUE) && issue_ready_i;
  assign result_ready_o = rst_ni;
  assign res_fire       = result_valid_i && result_ready_o;
  assign pop            = res_fire && (cnt_q != '0);
  assign push           = issue_fire && issue_accept_i && wr_rd_q;

  always_comb begin
    enc = '0;
    case (cmd_op_i)
      OP_LW:   enc = {cmd_imm_i, cmd_rs1_i, 3'b000, cmd_rd_i, OPCODE};
      OP_SW:   enc = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b001, cmd_imm_i[4:0], OPCODE};
      OP_DOTP: enc = {7'b0000000, cmd_rs2_i, cmd_rs1_i, 3'b010, cmd_rd_i, OPCODE};
      default: enc = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    id_d        = id_q;
    id_cnt_d    = id_cnt_q;
    wr_rd_d     = wr_rd_q;
    rd_d        = rd_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    q_id_d      = q_id_q;
    q_rd_d      = q_rd_q;
    q_vld_d     = q_vld_q;
    err_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;

    case (state_q)
      IDLE: if (cmd_fire) begin
        if (cmd_op_i == OP_INV) begin
          err_d = 1'b1;
        end else begin
          state_d = ISSUE;
          instr_d = enc;
          opa_d   = cmd_opa_i;
          opb_d   = cmd_opb_i;
          id_d    = id_cnt_q;
          rd_d    = cmd_rd_i;
          wr_rd_d = (cmd_op_i != OP_SW);
        end
      end
      ISSUE: if (issue_ready_i) begin
        if (issue_accept_i) begin
          state_d  = COMMIT;
          id_cnt_d = id_cnt_q + X_ID_WIDTH'(1);
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results return in issue order; a mismatching one is still consumed so the queue stays aligned.
    if (res_fire) begin
      if (pop) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_data_i;
        rsp_rd_d    = result_rd_i;
        if ((result_id_i != q_id_q[rd_ptr_q]) || (result_rd_i != q_rd_q[rd_ptr_q])) err_d = 1'b1;
        q_vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        err_d = 1'b1;
      end
    end

    if (push) begin
      q_id_d[wr_ptr_q]  = id_q;
      q_rd_d[wr_ptr_q]  = rd_q;
      q_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      id_q        <= '0;
      id_cnt_q    <= '0;
      wr_rd_q     <= 1'b0;
      rd_q        <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      q_id_q      <= '{default: '0};
      q_rd_q      <= '{default: '0};
      q_vld_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      id_q        <= id_d;
      id_cnt_q    <= id_cnt_d;
      wr_rd_q     <= wr_rd_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      q_id_q      <= q_id_d;
      q_rd_q      <= q_rd_d;
      q_vld_q     <= q_vld_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  assign issue_valid_o  = (state_q == ISSUE);
  assign issue_instr_o  = instr_q;
  assign issue_id_o     = id_q;
  assign issue_rs0_o    = opa_q;
  assign issue_rs1_o    = opb_q;
  assign commit_valid_o = (state_q == COMMIT);
  assign commit_kill_o  = 1'b0;
  assign commit_id_o    = id_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_rd_o       = rsp_rd_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_fir_xifu_issuer.sv
// Testbench for fir_xifu_issuer: directed and randomized transactions checked against a
// queue-based model of pending results, ID allocation and instruction encoding.
`timescale 1ns/1ps
module tb_fir_xifu_issuer;

  localparam int XW   = 4;
  localparam int MAXO = 4;
  localparam int NID  = 1 << XW;
  localparam logic [1:0] OP_INV  = 2'b00;
  localparam logic [1:0] OP_DOTP = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;
`ifdef FIR_XIFU_ISSUER_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic cmdValid = 1'b0, cmdReady;
  logic [1:0] cmdOp = '0;
  logic [4:0] cmdRs1 = '0, cmdRs2 = '0, cmdRd = '0;
  logic [11:0] cmdImm = '0;
  logic [31:0] cmdOpa = '0, cmdOpb = '0;
  logic issueValid, issueReady = 1'b0, issueAccept = 1'b0;
  logic [31:0] issueInstr, issueRs0, issueRs1;
  logic [XW-1:0] issueId, commitId;
  logic commitValid, commitKill;
  logic resultValid = 1'b0, resultReady;
  logic [XW-1:0] resultId = '0;
  logic [31:0] resultData = '0;
  logic [4:0] resultRd = '0;
  logic rspValid, errPulse;
  logic [31:0] rspData;
  logic [4:0] rspRd;

  typedef struct { int id; int rd; } pend_t;
  pend_t pq[$];
  int expId = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_xifu_issuer #(.X_ID_WIDTH(XW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_op_i(cmdOp),
    .cmd_rs1_i(cmdRs1), .cmd_rs2_i(cmdRs2), .cmd_rd_i(cmdRd), .cmd_imm_i(cmdImm),
    .cmd_opa_i(cmdOpa), .cmd_opb_i(cmdOpb),
    .issue_valid_o(issueValid), .issue_ready_i(issueReady), .issue_instr_o(issueInstr),
    .issue_id_o(issueId), .issue_rs0_o(issueRs0), .issue_rs1_o(issueRs1),
    .issue_accept_i(issueAccept),
    .commit_valid_o(commitValid), .commit_kill_o(commitKill), .commit_id_o(commitId),
    .result_valid_i(resultValid), .result_ready_o(resultReady), .result_id_i(resultId),
    .result_data_i(resultData), .result_rd_i(resultRd),
    .rsp_valid_o(rspValid), .rsp_data_o(rspData), .rsp_rd_o(rspRd), .err_o(errPulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field placement written as weighted sums of the instruction bit positions.
  function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [4:0] rd,
                                         input logic [11:0] imm);
    int unsigned v, r1, r2, d, im;
    r1 = rs1; r2 = rs2; d = rd; im = imm;
    v = 91;
    case (op)
      OP_LW:   v = v + d * 128 + r1 * 32768 + im * 1048576;
      OP_SW:   v = v + (im % 32) * 128 + 4096 + r1 * 32768 + r2 * 1048576 + (im / 32) * 33554432;
      OP_DOTP: v = v + d * 128 + 2 * 4096 + r1 * 32768 + r2 * 1048576;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit modelHazard(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    bit h;
    h = 1'b0;
    foreach (pq[i]) begin
      if (rs1 != 0 && int'(rs1) == pq[i].rd) h = 1'b1;
      if ((op == OP_SW || op == OP_DOTP) && rs2 != 0 && int'(rs2) == pq[i].rd) h = 1'b1;
    end
    return h & SB_EN;
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [11:0] imm,
                               input logic [31:0] opa, input logic [31:0] opb);
    cmdValid = 1'b1; cmdOp = op; cmdRs1 = rs1; cmdRs2 = rs2; cmdRd = rd;
    cmdImm = imm; cmdOpa = opa; cmdOpb = opb;
  endtask

  task automatic clearCmd();
    cmdValid = 1'b0; cmdOp = '0; cmdRs1 = '0; cmdRs2 = '0; cmdRd = '0;
    cmdImm = '0; cmdOpa = '0; cmdOpb = '0;
  endtask

  task automatic predictResult(input logic [XW-1:0] id, input logic [4:0] rd,
                               output bit expRsp, output bit expErr);
    if (pq.size() == 0) begin
      expRsp = 1'b0;
      expErr = 1'b1;
    end else begin
      expRsp = 1'b1;
      expErr = (int'(id) != pq[0].id) || (int'(rd) != pq[0].rd);
      void'(pq.pop_front());
    end
  endtask

  task automatic pickResult(input bit bad, output logic [XW-1:0] id, output logic [4:0] rd);
    if (pq.size() > 0) begin
      id = XW'(pq[0].id);
      rd = 5'(pq[0].rd);
      if (bad) begin
        if ($urandom_range(0, 1) == 0) id = id ^ XW'(1);
        else rd = rd ^ 5'd1;
      end
    end else begin
      id = XW'($urandom);
      rd = 5'($urandom);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_cmd_ready", cmdReady, 0);
    checkOutput("rst_issue_valid", issueValid, 0);
    checkOutput("rst_issue_instr", issueInstr, 0);
    checkOutput("rst_issue_id", issueId, 0);
    checkOutput("rst_issue_rs0", issueRs0, 0);
    checkOutput("rst_issue_rs1", issueRs1, 0);
    checkOutput("rst_commit_valid", commitValid, 0);
    checkOutput("rst_commit_kill", commitKill, 0);
    checkOutput("rst_commit_id", commitId, 0);
    checkOutput("rst_result_ready", resultReady, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_rsp_data", rspData, 0);
    checkOutput("rst_rsp_rd", rspRd, 0);
    checkOutput("rst_err", errPulse, 0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    clearCmd();
    issueReady = 1'b0; issueAccept = 1'b0; resultValid = 1'b0;
    #1;
    checkResetOutputs();
    tick();
    tick();
    rstN = 1'b1;
    pq.delete();
    expId = 0;
    #1;
    checkOutput("rel_result_ready", resultReady, 1);
    checkOutput("rel_cmd_ready", cmdReady, 1);
    tick();
  endtask

  task automatic returnResult(input logic [XW-1:0] id, input logic [4:0] rd, input logic [31:0] data);
    bit expRsp, expErr;
    predictResult(id, rd, expRsp, expErr);
    resultValid = 1'b1; resultId = id; resultRd = rd; resultData = data;
    tick();
    resultValid = 1'b0;
    checkOutput("res_rsp_valid", rspValid, expRsp);
    checkOutput("res_err", errPulse, expErr);
    if (expRsp) begin
      checkOutput("res_rsp_data", rspData, data);
      checkOutput("res_rsp_rd", rspRd, rd);
    end
    tick();
    checkOutput("res_rsp_pulse", rspValid, 0);
    checkOutput("res_err_pulse", errPulse, 0);
    checkOutput("res_cmd_ready", cmdReady, pq.size() < MAXO);
  endtask

  task automatic returnHead(input bit bad);
    logic [XW-1:0] id;
    logic [4:0] rd;
    pickResult(bad, id, rd);
    returnResult(id, rd, $urandom);
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [11:0] imm, input logic [31:0] opa,
                          input logic [31:0] opb, input bit accept, input int hold,
                          input bit withRes, input bit resBad);
    logic [31:0] expInstr, rData;
    logic [XW-1:0] rId;
    logic [4:0] rRd;
    bit expRsp, expErr;
    expInstr = encode(op, rs1, rs2, rd, imm);
    expRsp = 1'b0; expErr = 1'b0; rId = '0; rRd = '0; rData = $urandom;
    applyStimulus(op, rs1, rs2, rd, imm, opa, opb);
    #1;
    checkOutput("cmd_ready", cmdReady, 1);
    checkOutput("pre_issue_valid", issueValid, 0);
    tick();
    clearCmd();
    if (op == OP_INV) begin
      checkOutput("inv_err", errPulse, 1);
      checkOutput("inv_no_issue", issueValid, 0);
      checkOutput("inv_cmd_ready", cmdReady, pq.size() < MAXO);
      tick();
      checkOutput("inv_err_pulse", errPulse, 0);
      checkOutput("inv_still_idle", issueValid, 0);
      return;
    end
    checkOutput("issue_valid", issueValid, 1);
    checkOutput("issue_instr", issueInstr, expInstr);
    checkOutput("issue_id", issueId, expId);
    checkOutput("issue_rs0", issueRs0, opa);
    checkOutput("issue_rs1", issueRs1, opb);
    checkOutput("issue_cmd_ready", cmdReady, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_valid", issueValid, 1);
      checkOutput("hold_instr", issueInstr, expInstr);
      checkOutput("hold_id", issueId, expId);
      checkOutput("hold_no_commit", commitValid, 0);
    end
    issueReady = 1'b1;
    issueAccept = accept;
    if (withRes) begin
      pickResult(resBad, rId, rRd);
      predictResult(rId, rRd, expRsp, expErr);
      resultValid = 1'b1; resultId = rId; resultRd = rRd; resultData = rData;
    end
    tick();
    issueReady = 1'b0; issueAccept = 1'b0; resultValid = 1'b0;
    checkOutput("commit_valid", commitValid, accept);
    if (accept) begin
      checkOutput("commit_id", commitId, expId);
      checkOutput("commit_kill", commitKill, 0);
      if (op != OP_SW) pq.push_back('{id: expId, rd: int'(rd)});
      expId = (expId + 1) % NID;
    end
    checkOutput("issue_err", errPulse, (!accept) || expErr);
    checkOutput("issue_done", issueValid, 0);
    if (withRes) begin
      checkOutput("cc_rsp_valid", rspValid, expRsp);
      if (expRsp) begin
        checkOutput("cc_rsp_data", rspData, rData);
        checkOutput("cc_rsp_rd", rspRd, rRd);
      end
    end
    tick();
    checkOutput("commit_pulse", commitValid, 0);
    checkOutput("issue_err_pulse", errPulse, 0);
    checkOutput("issue_rsp_pulse", rspValid, 0);
    checkOutput("done_cmd_ready", cmdReady, pq.size() < MAXO);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    // lw example, then its result
    issueCmd(OP_LW, 5'd10, 5'd0, 5'd5, 12'h004, $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0);
    returnHead(1'b0);

    // dotp and sw examples from a clean state
    doReset();
    issueCmd(OP_DOTP, 5'd1, 5'd2, 5'd3, 12'h000, 32'h11, 32'h22, 1'b1, 1, 1'b0, 1'b0);
    returnResult('0, 5'd3, 32'h1234);
    issueCmd(OP_SW, 5'd7, 5'd6, 5'd0, 12'h7FF, $urandom, $urandom, 1'b1, 2, 1'b0, 1'b0);
    returnResult(XW'(2), 5'd9, 32'hDEAD);

    // rejected offload keeps the ID; invalid op is consumed with an error
    issueCmd(OP_LW, 5'd0, 5'd0, 5'd9, 12'h123, $urandom, $urandom, 1'b0, 1, 1'b0, 1'b0);
    issueCmd(OP_LW, 5'd0, 5'd0, 5'd9, 12'h124, $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0);
    issueCmd(OP_INV, 5'd0, 5'd0, 5'd1, 12'h000, $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0);
    returnHead(1'b1);

    // outstanding limit
    doReset();
    for (int i = 1; i <= MAXO; i++)
      issueCmd(OP_LW, 5'd0, 5'd0, 5'(i), 12'(i), $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(OP_LW, 5'd0, 5'd0, 5'd7, 12'h010, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("full_block", cmdReady, 0);
      checkOutput("full_no_issue", issueValid, 0);
      tick();
    end
    clearCmd();
    returnHead(1'b0);
    issueCmd(OP_LW, 5'd0, 5'd0, 5'd7, 12'h010, 32'h1, 32'h2, 1'b1, 0, 1'b1, 1'b0);
    while (pq.size() > 0) returnHead(1'b0);

    // ID wrap across 17 issues
    doReset();
    for (int i = 0; i < 17; i++)
      issueCmd(OP_SW, 5'($urandom), 5'($urandom), 5'd0, 12'($urandom), $urandom, $urandom,
               1'b1, 0, 1'b0, 1'b0);

`ifdef FIR_XIFU_ISSUER_SCOREBOARD_EN
    doReset();
    issueCmd(OP_LW, 5'd0, 5'd0, 5'd5, 12'h000, $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(OP_DOTP, 5'd5, 5'd0, 5'd8, 12'h000, 32'h3, 32'h4);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("sb_rs1_block", cmdReady, 0);
      tick();
    end
    applyStimulus(OP_SW, 5'd0, 5'd5, 5'd0, 12'h000, 32'h3, 32'h4);
    #1;
    checkOutput("sb_rs2_block", cmdReady, 0);
    clearCmd();
    tick();
    returnHead(1'b0);
    issueCmd(OP_DOTP, 5'd5, 5'd0, 5'd8, 12'h000, 32'h3, 32'h4, 1'b1, 0, 1'b0, 1'b0);
    while (pq.size() > 0) returnHead(1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      logic [4:0] r1, r2, rdv;
      logic [11:0] im;
      op  = ($urandom_range(0, 9) == 0) ? OP_INV : 2'($urandom_range(1, 3));
      r1  = 5'($urandom);
      r2  = 5'($urandom);
      rdv = 5'($urandom);
      im  = 12'($urandom);
      if ($urandom_range(0, 3) == 0) returnHead($urandom_range(0, 5) == 0);
      while (pq.size() >= MAXO || modelHazard(op, r1, r2)) returnHead(1'b0);
      issueCmd(op, r1, r2, rdv, im, $urandom, $urandom, $urandom_range(0, 7) != 0,
               $urandom_range(0, 2), (pq.size() > 0) && ($urandom_range(0, 2) == 0),
               $urandom_range(0, 4) == 0);
    end
    while (pq.size() > 0) returnHead(1'b0);
    returnHead(1'b0);

    // asynchronous reset in the middle of ISSUE, then of COMMIT
    applyStimulus(OP_LW, 5'd0, 5'd0, 5'd4, 12'h001, 32'hA, 32'hB);
    tick();
    clearCmd();
    checkOutput("mid_issue_valid", issueValid, 1);
    doReset();
    applyStimulus(OP_DOTP, 5'd0, 5'd0, 5'd4, 12'h000, 32'hA, 32'hB);
    tick();
    clearCmd();
    issueReady = 1'b1;
    issueAccept = 1'b1;
    tick();
    issueReady = 1'b0;
    issueAccept = 1'b0;
    checkOutput("mid_commit_valid", commitValid, 1);
    doReset();
    returnHead(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
